execute_stage_pipe: RTL and testbench

EXECUTE_STAGE_PIPE -- requirements
Module: execute_stage_pipe

---
 rtl/execute_stage_pipe.sv | 195 +++++++++++++++++++
 tb/tb_execute_stage_pipe.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_pipe.sv
// Execute stage: single-cycle ALU with a multi-cycle multiplier and a one-entry
// valid/ready output register feeding the memory stage.
module execute_stage_pipe #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             am,
  input  logic             wbs,
  input  logic             wme,
  input  logic             wm,
  input  logic             ni,
  input  logic [1:0]       mm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult_out,
  output logic [WIDTH-1:0] memData_out,
  output logic             wbs_out,
  output logic             wme_out,
  output logic             wm_out,
  output logic             ni_out,
  output logic [1:0]       mm_out,
  output logic             flagN,
  output logic             flagZ
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] hold_a;
  logic [WIDTH-1:0] hold_b;
  logic             hold_am;
  logic             hold_wbs;
  logic             hold_wme;
  logic             hold_wm;
  logic             hold_ni;
  logic [1:0]       hold_mm;

  logic             accept;
  logic             multi_mul;
  logic             mul_done;
  logic             load_en;

  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_am;
  logic             sel_wbs;
  logic             sel_wme;
  logic             sel_wm;
  logic             sel_ni;
  logic [1:0]       sel_mm;
  logic [WIDTH-1:0] result;

  assign in_ready  = !rst && (state == IDLE) && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign multi_mul = (ALUop == OP_MUL) && (MUL_CYCLES > 1);
  assign mul_done  = (state == MUL_BUSY) && (cnt == '0) && (!out_valid || out_ready);
  assign load_en   = (accept && !multi_mul) || mul_done;

  // While a multiply is in flight the captured operands drive the ALU.
  always_comb begin
    sel_op  = ALUop;
    sel_a   = srcA;
    sel_b   = srcB;
    sel_am  = am;
    sel_wbs = wbs;
    sel_wme = wme;
    sel_wm  = wm;
    sel_ni  = ni;
    sel_mm  = mm;
    if (state == MUL_BUSY) begin
      sel_op  = OP_MUL;
      sel_a   = hold_a;
      sel_b   = hold_b;
      sel_am  = hold_am;
      sel_wbs = hold_wbs;
      sel_wme = hold_wme;
      sel_wm  = hold_wm;
      sel_ni  = hold_ni;
      sel_mm  = hold_mm;
    end
  end

  always_comb begin
    result = '0;
    case (sel_op)
      OP_ADD:  result = sel_a + sel_b;
      OP_SUB:  result = sel_a - sel_b;
      OP_AND:  result = sel_a & sel_b;
      OP_OR:   result = sel_a | sel_b;
      OP_XOR:  result = sel_a ^ sel_b;
      OP_SLL:  result = sel_a << sel_b[SHW-1:0];
      OP_SRL:  result = sel_a >> sel_b[SHW-1:0];
      OP_MUL:  result = sel_a * sel_b;
      default: result = '0;
    endcase
  end

  // Flush only squashes valid/state; data outputs may keep stale values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      out_valid     <= 1'b0;
      ALUresult_out <= '0;
      memData_out   <= '0;
      wbs_out       <= 1'b0;
      wme_out       <= 1'b0;
      wm_out        <= 1'b0;
      ni_out        <= 1'b0;
      mm_out        <= 2'b00;
      flagN         <= 1'b0;
      flagZ         <= 1'b0;
      hold_a        <= '0;
      hold_b        <= '0;
      hold_am       <= 1'b0;
      hold_wbs      <= 1'b0;
      hold_wme      <= 1'b0;
      hold_wm       <= 1'b0;
      hold_ni       <= 1'b0;
      hold_mm       <= 2'b00;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_en) begin
        out_valid     <= 1'b1;
        ALUresult_out <= result;
        memData_out   <= sel_am ? sel_b : '0;
        wbs_out       <= sel_wbs;
        wme_out       <= sel_wme;
        wm_out        <= sel_wm;
        ni_out        <= sel_ni;
        mm_out        <= sel_mm;
        flagN         <= result[WIDTH-1];
        flagZ         <= (result == '0);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && multi_mul) begin
            hold_a   <= srcA;
            hold_b   <= srcB;
            hold_am  <= am;
            hold_wbs <= wbs;
            hold_wme <= wme;
            hold_wm  <= wm;
            hold_ni  <= ni;
            hold_mm  <= mm;
            cnt      <= CNT_INIT;
            state    <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (mul_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Scoreboard bench for execute_stage_pipe: a 16-bit/4-cycle-MUL instance for the
// main tests and a 32-bit instance for the wide shift-amount masking case.
module tb_execute_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  ALUop = 3'b000;
  logic [15:0] srcA = '0;
  logic [15:0] srcB = '0;
  logic        am = 1'b0;
  logic        wbs = 1'b0;
  logic        wme = 1'b0;
  logic        wm = 1'b0;
  logic        ni = 1'b0;
  logic [1:0]  mm = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] ALUresult_out;
  logic [15:0] memData_out;
  logic        wbs_out, wme_out, wm_out, ni_out;
  logic [1:0]  mm_out;
  logic        flagN, flagZ;

  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [2:0]  op32 = 3'b000;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        zero1 = 1'b0;
  logic [1:0]  zero2 = 2'b00;
  logic        one1 = 1'b1;
  logic        out_valid32;
  logic [31:0] res32, mem32;
  logic        wbs32, wme32, wm32, ni32;
  logic [1:0]  mm32;
  logic        n32, z32;

  int errors = 0;
  int checks = 0;
  logic [39:0] sb_q[$];
  logic [39:0] obs;
  logic [39:0] exp_v;

  assign obs = {ALUresult_out, memData_out, wbs_out, wme_out, wm_out, ni_out, mm_out, flagN, flagZ};

  execute_stage_pipe #(.WIDTH(16), .MUL_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .srcA(srcA), .srcB(srcB), .am(am), .wbs(wbs), .wme(wme), .wm(wm),
    .ni(ni), .mm(mm), .out_valid(out_valid), .out_ready(out_ready),
    .ALUresult_out(ALUresult_out), .memData_out(memData_out), .wbs_out(wbs_out),
    .wme_out(wme_out), .wm_out(wm_out), .ni_out(ni_out), .mm_out(mm_out),
    .flagN(flagN), .flagZ(flagZ)
  );

  execute_stage_pipe #(.WIDTH(32), .MUL_CYCLES(4)) u_dut32 (
    .clk(clk), .rst(rst), .flush(zero1), .in_valid(in_valid32), .in_ready(in_ready32),
    .ALUop(op32), .srcA(a32), .srcB(b32), .am(zero1), .wbs(zero1), .wme(zero1), .wm(zero1),
    .ni(zero1), .mm(zero2), .out_valid(out_valid32), .out_ready(one1),
    .ALUresult_out(res32), .memData_out(mem32), .wbs_out(wbs32),
    .wme_out(wme32), .wm_out(wm32), .ni_out(ni32), .mm_out(mm32),
    .flagN(n32), .flagZ(z32)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic m,
                                        input logic [5:0] ctrl);
    logic [15:0] r;
    logic [31:0] p;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a + (~b) + 16'd1;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      default: begin
        p = {16'd0, a} * {16'd0, b};
        r = p[15:0];
      end
    endcase
    return {r, (m ? b : 16'd0), ctrl, r[15], (r == 16'd0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation; record its expected entry if the stage takes it this cycle.
  task automatic drive_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input logic [5:0] ctrl, output logic acc);
    ALUop = op;
    srcA = a;
    srcB = b;
    am = m;
    {wbs, wme, wm, ni, mm} = ctrl;
    in_valid = 1'b1;
    #1;
    acc = in_ready;
    if (acc) sb_q.push_back(model(op, a, b, m, ctrl));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (obs !== 40'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    logic acc;
    out_ready = 1'b1;
    drive_op(3'b000, 16'd2, 16'd3, 1'b0, 6'b100000, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("[TB] FAIL add_accept: got %b expected 1", acc);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ALUresult_out !== 16'd5 || memData_out !== 16'd0 ||
        wbs_out !== 1'b1 || flagN !== 1'b0 || flagZ !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_basic: got v=%b r=%h m=%h wbs=%b n=%b z=%b expected v=1 r=0005 m=0000 wbs=1 n=0 z=0",
               out_valid, ALUresult_out, memData_out, wbs_out, flagN, flagZ);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("[TB] FAIL add_entry: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_sub();
    logic acc;
    drive_op(3'b001, 16'd1, 16'd2, 1'b0, 6'b000000, acc);
    tick();
    checks++;
    if (out_valid !== 1'b1 || ALUresult_out !== 16'hFFFF || flagN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sub_negative: got v=%b r=%h n=%b expected v=1 r=ffff n=1",
               out_valid, ALUresult_out, flagN);
    end
    exp_v = sb_q.pop_front();
    drive_op(3'b001, 16'd7, 16'd7, 1'b0, 6'b010101, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("[TB] FAIL sub_b2b_accept: got %b expected 1", acc);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ALUresult_out !== 16'h0000 || flagZ !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sub_zero: got v=%b r=%h z=%b expected v=1 r=0000 z=1",
               out_valid, ALUresult_out, flagZ);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("[TB] FAIL sub_entry: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_alu_ops();
    logic acc;
    logic got;
    logic [15:0] a, b;
    logic [5:0] ctrl;
    logic m;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      ctrl = 6'($urandom);
      m = 1'($urandom);
      if (i == 7) begin
        a = 16'hFFFF;
        b = 16'hFFFF;
      end
      drive_op(3'(i), a, b, m, ctrl, acc);
      checks++;
      if (acc !== 1'b1) begin
        errors++; $display("[TB] FAIL op%0d_accept: got %b expected 1", i, acc);
      end
      tick();
      in_valid = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        if (out_valid === 1'b1) got = 1'b1;
        else tick();
      end
      checks++;
      if (!got) begin
        errors++; $display("[TB] FAIL op%0d_timeout: got no out_valid expected out_valid=1", i);
        sb_q.delete();
      end else if (sb_q.size() == 0) begin
        errors++; $display("[TB] FAIL op%0d_unexpected: got %h expected no entry", i, obs);
      end else begin
        exp_v = sb_q.pop_front();
        if (obs !== exp_v) begin
          errors++; $display("[TB] FAIL op%0d_entry: got %h expected %h", i, obs, exp_v);
        end
      end
      tick();
    end
  endtask

  task automatic test_mul();
    logic acc;
    logic bad;
    drive_op(3'b111, 16'h0050, 16'h0007, 1'b1, 6'b001011, acc);
    tick();
    in_valid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL mul_busy: got in_ready/out_valid high expected both 0 for 4 cycles");
    end
    checks++;
    if (out_valid !== 1'b1 || ALUresult_out !== 16'h0230 || memData_out !== 16'h0007) begin
      errors++;
      $display("[TB] FAIL mul_result: got v=%b r=%h m=%h expected v=1 r=0230 m=0007",
               out_valid, ALUresult_out, memData_out);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("[TB] FAIL mul_entry: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [15:0] av[3] = '{16'h1111, 16'h2222, 16'h7FFF};
    logic [15:0] bv[3] = '{16'h0001, 16'h0100, 16'h0001};
    out_ready = 1'b0;
    drive_op(3'b000, av[0], bv[0], 1'b1, 6'b110000, acc);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive_op(3'b000, av[1], bv[1], 1'b0, 6'b000111, acc);
      checks++;
      if (acc !== 1'b0 || out_valid !== 1'b1 || obs !== sb_q[0]) begin
        errors++;
        $display("[TB] FAIL stall_hold: got ready=%b v=%b %h expected ready=0 v=1 %h",
                 acc, out_valid, obs, sb_q[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || sb_q.size() == 0) begin
        errors++; $display("[TB] FAIL drain%0d_valid: got v=%b expected v=1", j, out_valid);
      end else begin
        exp_v = sb_q.pop_front();
        if (obs !== exp_v) begin
          errors++; $display("[TB] FAIL drain%0d_entry: got %h expected %h", j, obs, exp_v);
        end
      end
      if (j < 2) begin
        drive_op(3'b000, av[j+1], bv[j+1], 1'(j), 6'(j + 1), acc);
        checks++;
        if (acc !== 1'b1) begin
          errors++; $display("[TB] FAIL drain%0d_accept: got %b expected 1", j, acc);
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++; $display("[TB] FAIL drain_empty: got v=%b q=%0d expected v=0 q=0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_flush();
    logic acc;
    logic bad;
    out_ready = 1'b1;
    drive_op(3'b111, 16'h0003, 16'h0005, 1'b0, 6'b100000, acc);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready);
    end
    tick();
    flush = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_recover: got ready=%b v=%b expected ready=1 v=0", in_ready, out_valid);
    end
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL flush_mul_squashed: got out_valid=1 expected 0");
    end
    out_ready = 1'b0;
    drive_op(3'b011, 16'h00F0, 16'h000F, 1'b0, 6'b000001, acc);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb_q.delete();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_entry: got v=%b expected 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    logic acc;
    logic bad;
    out_ready = 1'b0;
    drive_op(3'b000, 16'h8000, 16'h0123, 1'b1, 6'b111111, acc);
    tick();
    in_valid = 1'b0;
    exp_v = sb_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== exp_v) begin
      errors++; $display("[TB] FAIL pre_reset_entry: got v=%b %h expected v=1 %h", out_valid, obs, exp_v);
    end
    out_ready = 1'b1;
    drive_op(3'b111, 16'h0009, 16'h0009, 1'b1, 6'b101010, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("[TB] FAIL mul_accept_on_consume: got %b expected 1", acc);
    end
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 40'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_mul: got v=%b ready=%b %h expected v=0 ready=0 0",
               out_valid, in_ready, obs);
    end
    rst = 1'b0;
    sb_q.delete();
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL reset_mul_aborted: got out_valid=1 expected 0");
    end
  endtask

  task automatic test_shift32();
    op32 = 3'b101;
    a32 = 32'd1;
    b32 = 32'd35;
    in_valid32 = 1'b1;
    tick();
    op32 = 3'b110;
    a32 = 32'h8000_0000;
    b32 = 32'd33;
    checks++;
    if (out_valid32 !== 1'b1 || res32 !== 32'h0000_0008 || z32 !== 1'b0) begin
      errors++; $display("[TB] FAIL sll32: got v=%b r=%h expected v=1 r=00000008", out_valid32, res32);
    end
    tick();
    in_valid32 = 1'b0;
    checks++;
    if (out_valid32 !== 1'b1 || res32 !== 32'h4000_0000 || n32 !== 1'b0) begin
      errors++; $display("[TB] FAIL srl32: got v=%b r=%h expected v=1 r=40000000", out_valid32, res32);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    test_shift32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
